// File: rtl/cpu_pkg.sv
// Shared types for the processor memory path: FSM state and owner encodings.
package cpu_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the memory port; MEM_ARB_RR_EN selects strict alternation,
// otherwise LS priority with an IF starvation guard.
module mem_arb_pick
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic if_req_i,
  input  logic ls_req_i,
  output logic if_win_o,
  output logic ls_win_o
);

  logic both;
  logic if_only;
  logic ls_only;

  assign both    = if_req_i & ls_req_i;
  assign if_only = if_req_i & ~ls_req_i;
  assign ls_only = ls_req_i & ~if_req_i;

`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;

  always_comb begin
    if_win_o = 1'b0;
    ls_win_o = 1'b0;
    last_d   = last_q;
    if (en_i) begin
      unique case (1'b1)
        both: begin
          if (last_q == OWN_IF) ls_win_o = 1'b1;
          else                  if_win_o = 1'b1;
        end
        ls_only: ls_win_o = 1'b1;
        if_only: if_win_o = 1'b1;
        default: ;
      endcase
    end
    if (if_win_o) last_d = OWN_IF;
    if (ls_win_o) last_d = OWN_LS;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= OWN_IF;
    else        last_q <= last_d;
  end
`else
  logic [3:0] starve_q, starve_d;
  logic       force_if;

  assign force_if = (starve_q == 4'(STARVE_MAX));

  always_comb begin
    if_win_o = 1'b0;
    ls_win_o = 1'b0;
    starve_d = starve_q;
    if (en_i) begin
      unique case (1'b1)
        both: begin
          if (force_if) if_win_o = 1'b1;
          else          ls_win_o = 1'b1;
        end
        ls_only: ls_win_o = 1'b1;
        if_only: if_win_o = 1'b1;
        default: ;
      endcase
      // a denied IF in a tie ages; any IF win resets the guard
      if (both && !if_win_o) starve_d = starve_q + 4'd1;
      if (if_win_o)          starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of LS priority.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  state_e        state_q;
  owner_e        owner_q;
  logic          we_q;
  logic [2:0]    wait_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          if_rvalid_q;
  logic          ls_rvalid_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] ls_rdata_q;
  logic          if_win;
  logic          ls_win;
  logic          arb_en;
  logic          last_wait;

  assign arb_en = (state_q == ST_IDLE);

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk     (clk),
    .reset   (reset),
    .en_i    (arb_en),
    .if_req_i(if_req),
    .ls_req_i(ls_req),
    .if_win_o(if_win),
    .ls_win_o(ls_win)
  );

  // cycle on which mem_rdata is valid for the in-flight access
  assign last_wait = (WAIT_CYCLES == 0)
                   ? (state_q == ST_ACCESS)
                   : (state_q == ST_WAIT && wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      wait_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (if_win || ls_win) begin
            owner_q    <= ls_win ? OWN_LS : OWN_IF;
            we_q       <= ls_win & ls_we;
            mem_en_q   <= 1'b1;
            mem_we_q   <= ls_win & ls_we;
            mem_addr_q <= ls_win ? ls_addr : if_addr;
            if (ls_win) mem_wdata_q <= ls_wdata;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          wait_q  <= '0;
          state_q <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          if (last_wait) state_q <= ST_RESP;
          else           wait_q  <= wait_q + 3'd1;
        end
        ST_RESP: state_q <= ST_IDLE;
      endcase
      if (last_wait && !we_q) begin
        if (owner_q == OWN_LS) begin
          ls_rvalid_q <= 1'b1;
          ls_rdata_q  <= mem_rdata;
        end else begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= mem_rdata;
        end
      end
    end
  end

  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
